// File: rtl/mul32_seq.sv
// Sequential shift-and-add unsigned multiplier: one accumulator bit retired per BUSY cycle.
// Valid/ready handshake on both sides; all handshake outputs come straight from flops.
module mul32_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [WIDTH-1:0]     pp;
    logic [WIDTH:0]       sum;

    always_comb begin
        pp  = mcand_q & {WIDTH{acc_q[0]}};
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, pp};

        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = x;
                    acc_d   = {{WIDTH{1'b0}}, y};
                    cnt_d   = 6'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // carry lands in the top bit, the consumed multiplier bit falls off the bottom
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = acc_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Scoreboard bench for mul32_seq: stimulus pushes expected products, a monitor pops on each handshake.
module tb_mul32_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] p;
    logic        busy;

    int errCount;
    int checkCount;
    logic [63:0] expQ[$];

    mul32_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, latency/busy check, optional DONE stall with hold checks, release.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [63:0] expVal,
                                 input int stall);
        int waitCycles;
        int cycles;
        int busyCount;
        waitCycles = 0;
        while (!in_ready && waitCycles < 100) begin
            stepCycle();
            waitCycles++;
        end
        checkOutput("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        x        = a;
        y        = b;
        out_ready = 1'b0;
        expQ.push_back(expVal);
        stepCycle();
        cycles    = 0;
        busyCount = 0;
        while (!out_valid && cycles < 100) begin
            if (busy) busyCount++;
            in_valid = 1'($urandom_range(0, 1));
            x        = $urandom;
            y        = $urandom;
            stepCycle();
            cycles++;
        end
        checkOutput("latency_edges", 64'(cycles), 64'd32);
        checkOutput("busy_cycles", 64'(busyCount), 64'd32);
        for (int s = 0; s < stall; s++) begin
            checkOutput("stall_out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("stall_p_hold", p, expVal);
            stepCycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
        checkOutput("idle_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("idle_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    // Monitor: the product is consumed at the edge following a negedge with out_valid && out_ready.
    initial begin
        logic [63:0] expVal;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_product", p, 64'd0);
                    if (p == 64'd0) begin
                        errCount++;
                        $display("[TB] FAIL unexpected_product: got out_valid with empty scoreboard");
                    end
                end else begin
                    expVal = expQ.pop_front();
                    checkOutput("product", p, expVal);
                end
            end
        end
    end

    initial begin
        int validSeen;
        logic [31:0] ra;
        logic [31:0] rb;
        errCount   = 0;
        checkCount = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        x          = '0;
        y          = '0;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_p", p, 64'd0);

        // IDLE with in_valid low must hold
        stepCycle();
        stepCycle();
        checkOutput("idle_hold_busy", {63'd0, busy}, 64'd0);

        applyStimulus(32'h00000003, 32'h00000005, 64'h000000000000000F, 0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1);
        applyStimulus(32'h80000000, 32'h00000002, 64'h0000000100000000, 0);
        applyStimulus(32'h00000000, 32'hDEADBEEF, 64'h0000000000000000, 2);
        applyStimulus(32'h12345678, 32'h87654321, 64'h09A0CD0570B88D78, 10);

        // Abort: reset lands on the 10th BUSY cycle while inputs wiggle
        in_valid = 1'b1;
        x        = 32'h00000003;
        y        = 32'h00000005;
        expQ.push_back(64'h000000000000000F);
        stepCycle();
        for (int k = 1; k < 10; k++) begin
            in_valid = 1'(k % 2);
            x        = $urandom;
            y        = $urandom;
            stepCycle();
        end
        checkOutput("abort_busy_before_rst", {63'd0, busy}, 64'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        stepCycle();
        rst = 1'b0;
        void'(expQ.pop_back());
        checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("abort_p", p, 64'd0);
        validSeen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) validSeen++;
            stepCycle();
        end
        checkOutput("abort_no_out_valid", 64'(validSeen), 64'd0);
        applyStimulus(32'h00000003, 32'h00000005, 64'h000000000000000F, 0);

        for (int n = 0; n < 100; n++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus(ra, rb, {32'd0, ra} * {32'd0, rb}, int'($urandom_range(0, 3)));
        end

        stepCycle();
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mul32_seq.md
MUL32_SEQ -- requirements
Module: mul32_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands x, y are presented.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port x  input  WIDTH  multiplicand, unsigned.
REQ-007 SHALL have port y  input  WIDTH  multiplier, unsigned.
REQ-008 SHALL have port out_valid  output  1  product p is valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes p this cycle.
REQ-010 SHALL have port p  output  2*WIDTH  unsigned product x*y.
REQ-011 SHALL have port busy  output  1  high while state is BUSY.

Function
REQ-012 SHALL implement three states: IDLE, BUSY, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE, busy=1 only in BUSY.
REQ-014 Accept: an edge with in_valid=1 and in_ready=1 SHALL latch x into the multiplicand register, load y into the low half of a 2*WIDTH accumulator, clear the high half, clear the 6-bit counter, and enter BUSY.
REQ-015 In IDLE with in_valid=0, state and registers SHALL hold.
REQ-016 Each BUSY edge SHALL compute partial product = multiplicand AND {WIDTH{acc[0]}}.
REQ-017 Each BUSY edge SHALL add that partial product to acc[2W-1:W] as a WIDTH+1-bit sum.
REQ-018 Each BUSY edge SHALL shift {carry, sum, acc[W-1:0]} right by one into acc.
REQ-019 Each BUSY edge SHALL increment the counter.
REQ-020 The BUSY edge on which the counter equals WIDTH-1 SHALL be the last iteration and SHALL enter DONE; BUSY lasts exactly WIDTH=32 edges.
REQ-021 Latency: out_valid SHALL be 1 exactly 32 clock edges after the accept edge, independent of operand values; there is no early termination.
REQ-022 p SHALL equal acc; p SHALL be exact modulo 2^(2*WIDTH), and no overflow is possible.
REQ-023 In DONE, p and out_valid SHALL hold stable while out_ready=0, for any number of cycles.
REQ-024 In DONE, an edge with out_ready=1 SHALL return to IDLE; p SHALL retain its last value, while out_valid=0.
REQ-025 Minimum throughput SHALL be one product per 34 cycles: 1 IDLE accept cycle, 32 BUSY cycles, at least 1 DONE cycle.
REQ-026 in_valid, x and y SHALL be ignored outside IDLE; input changes during BUSY/DONE SHALL NOT affect p.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 No combinational path SHALL exist from in_valid or out_ready to in_ready or out_valid; all handshake outputs are decoded from registered state.

Reset
REQ-029 When rst=1 at an edge, the block SHALL enter IDLE.
REQ-030 When rst=1 at an edge, acc, multiplicand and counter SHALL be cleared to 0.
REQ-031 After reset: in_ready=1, out_valid=0, busy=0, p=0.
REQ-032 rst SHALL take priority over any simultaneous handshake on the same edge.
REQ-033 Reset in BUSY or DONE SHALL abort the operation and discard the partial result; no out_valid pulse SHALL follow.
REQ-034 Outputs SHALL NOT be required to be defined before the first reset edge.

Verification
REQ-035 Bench SHALL cover: reset, then accept x=0x00000003, y=0x00000005 -> busy=1 for 32 cycles, then out_valid=1 with p=0x000000000000000F on the 32nd edge after accept.
REQ-036 Bench SHALL cover: x=0xFFFFFFFF, y=0xFFFFFFFF -> p=0xFFFFFFFE00000001.
REQ-037 Bench SHALL cover: x=0x80000000, y=0x00000002 -> p=0x0000000100000000.
REQ-038 Bench SHALL cover: x=0x00000000, y=0xDEADBEEF -> p=0, still after 32 cycles.
REQ-039 Bench SHALL cover: x=0x12345678, y=0x87654321, out_ready=0 for 10 cycles in DONE -> p=0x09A0CD0570B88D78 held stable and out_valid=1 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-040 Bench SHALL cover: rst=1 on the 10th BUSY cycle, with in_valid toggling and x/y changing during BUSY -> next cycle in_ready=1, out_valid=0, p=0; a fresh 3*5 then yields 0xF.
REQ-041 Bench SHALL cover: 100 $random operand pairs checked against x*y in a 64-bit reference model, with randomized out_ready stalls; zero mismatches required.
